// File: rtl/bp_pkg.sv
// Shared definitions for the branch outcome tracker and its in-flight queue.
package bp_pkg;

    localparam int BP_DEPTH_DEF = 4;
    localparam int BP_TAG_W_DEF = 4;
    localparam int BP_CNT_W_DEF = 16;

    // One in-flight branch at the default tag width. The queue stores the
    // same packing, {tag, pred}, with the tag in the upper bits, so the
    // prediction is always bit 0 whatever the tag width is.
    typedef struct packed {
        logic [BP_TAG_W_DEF-1:0] tag;
        logic                    pred;
    } br_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of in-flight branches: push at the tail, pop at the head,
// and a synchronous clear that drops everything and rewinds both pointers.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEF,
    parameter int W     = BP_TAG_W_DEF + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    // A pop on an empty queue is ignored so the count can never underflow.
    assign empty  = (count == '0);
    assign do_pop = pop & ~empty;
    assign head   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; a clear or reset on the same edge wins over a write.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/branch_outcome_tracker.sv
// Client side of the 2-bit branch predictor: requests predictions for fetched
// branches, tracks them in order, reports outcomes back to the predictor,
// squashes younger branches on a mispredict and keeps saturating statistics.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1 (fetch_branch/fetch_ready, resolve_valid/resolve_ready); ready never
// depends on valid, and valid may be raised or dropped freely.
module branch_outcome_tracker
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEF,
    parameter int TAG_W = BP_TAG_W_DEF,
    parameter int CNT_W = BP_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_branch,
    input  logic [TAG_W-1:0] fetch_tag,
    output logic             fetch_ready,
    output logic             fetch_pred_valid,
    output logic             fetch_pred,
    output logic             pred_request,
    input  logic             pred_prediction,
    output logic             pred_result,
    output logic             pred_taken,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             resolve_ready,
    output logic [TAG_W-1:0] resolve_tag,
    output logic             mispredict,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TAG_W + 1;

    logic             pending_q;
    logic [TAG_W-1:0] pending_tag_q;
    logic [AW:0]      q_count;
    logic [EW-1:0]    q_head;
    logic             q_empty;
    logic [AW+1:0]    occupancy;
    logic             res_accept;
    logic             res_mis;
    logic             capture;

    // A pending capture already owns a slot, so it counts toward occupancy.
    assign occupancy   = {1'b0, q_count} + {{(AW+1){1'b0}}, pending_q};
    assign fetch_ready = (occupancy < (AW+2)'(DEPTH));

    // Combinational: the predictor registers its prediction on this same edge.
    assign pred_request = fetch_branch & fetch_ready & ~rst;

    // The prediction arrives the cycle after the request; show it as it lands.
    assign fetch_pred_valid = pending_q;
    assign fetch_pred       = pending_q & pred_prediction;

    // Resolvability follows the stored count only, so a capture landing this
    // cycle cannot be resolved until the next one.
    assign resolve_ready = ~q_empty;
    assign resolve_tag   = q_head[EW-1:1];
    assign res_accept    = resolve_valid & resolve_ready;
    assign res_mis       = res_accept & (q_head[0] != resolve_taken);

    // A capture that lands on a mispredict edge is younger than the branch
    // being resolved, so it is squashed along with the rest of the queue.
    assign capture = pending_q & ~res_mis;

    bp_inflight_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (res_mis),
        .push      (capture),
        .push_data ({pending_tag_q, pred_prediction}),
        .pop       (res_accept),
        .count     (q_count),
        .head      (q_head),
        .empty     (q_empty)
    );

    // Remember an accepted request until its prediction comes back next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= 1'b0;
            pending_tag_q <= '0;
        end else begin
            pending_q     <= pred_request & ~res_mis;
            pending_tag_q <= fetch_tag;
        end
    end

    // One-cycle outcome and mispredict pulses following a resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_result <= 1'b0;
            pred_taken  <= 1'b0;
            mispredict  <= 1'b0;
            flush       <= 1'b0;
        end else begin
            pred_result <= res_accept;
            pred_taken  <= res_accept & resolve_taken;
            mispredict  <= res_mis;
            flush       <= res_mis;
        end
    end

    // Saturating statistics: stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (res_accept && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (res_mis && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule
